// File: rtl/divu_seq_if.sv
// Request/response bundle for the sequential unsigned divider.
// The slave modport is the divider side; the master modport is the requester side.
interface divu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divu_seq.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per cycle, with all
// trial subtractions done by a single shared cla adder.
module divu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  divu_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             ovld_q, ovld_d;
  logic             init_q;

  logic [WIDTH:0]   shift;
  logic [WIDTH-1:0] dvsr_n;
  logic [WIDTH-1:0] diff;
  logic             co;
  logic             no_borrow;
  logic             in_ready;

  assign shift  = {r_q, q_q[WIDTH-1]};
  assign dvsr_n = ~dvsr_q;

  cla #(
    .Width (WIDTH)
  ) u_cla (
    .a_i   (shift[WIDTH-1:0]),
    .b_i   (dvsr_n),
    .cin_i (1'b1),
    .sum_o (diff)
  );

  // The adder exports no carry; rebuild it from the top operand bits and the sum MSB.
  assign co = (shift[WIDTH-1] & dvsr_n[WIDTH-1]) |
              ((shift[WIDTH-1] ^ dvsr_n[WIDTH-1]) & ~diff[WIDTH-1]);
  assign no_borrow = shift[WIDTH] | co;

  assign in_ready = (state_q == StIdle) & init_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvsr_d  = dvsr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovld_d  = ovld_q;
    if (flush) begin
      state_d = StIdle;
      ovld_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready) begin
            dvsr_d  = bus.divisor;
            q_d     = bus.dividend;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = (bus.divisor == '0);
            state_d = (bus.divisor == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          r_d   = no_borrow ? diff : shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], no_borrow};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StDone;
        end
        StDone: begin
          // First DONE cycle registers out_valid; results are frozen from here on.
          if (!ovld_q) begin
            ovld_d = 1'b1;
          end else if (bus.out_ready) begin
            ovld_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovld_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovld_q  <= ovld_d;
      init_q  <= 1'b1;
    end
  end

  // On divide-by-zero Q still holds the sampled dividend, which becomes the remainder.
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = ovld_q;
  assign bus.quotient    = ovld_q ? (dbz_q ? '1 : q_q) : '0;
  assign bus.remainder   = ovld_q ? (dbz_q ? q_q : r_q) : '0;
  assign bus.div_by_zero = ovld_q & dbz_q;

endmodule

// Shared adder: generate/propagate carry chain, sum only, no carry-out port.
module cla #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o
);
  logic [Width-1:0] g;
  logic [Width-1:0] p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      sum_o[i] = p[i] ^ carry;
      carry    = g[i] | (p[i] & carry);
    end
  end
endmodule

// File: tb/tb_divu_seq.sv
// Directed and light random checks of divu_seq: latency, boundaries, backpressure,
// flush and asynchronous reset.
module tb_divu_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  divu_seq_if bus();

  divu_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the accept edge has passed.
  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs);
    int n = 0;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    check("issue_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid is seen.
  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic expect_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                               input logic dbz);
    check({tag, "_q"}, bus.quotient, q);
    check({tag, "_r"}, bus.remainder, r);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(dbz));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [31:0] q, input logic [31:0] r, input logic dbz,
                         input int lat);
    issue(dvd, dvs);
    wait_result(tag, lat);
    expect_result(tag, q, r, dbz);
    drain(tag);
  endtask

  initial begin
    int rose;
    logic [31:0] dvd, dvs, eq, er;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    #2 rst_n = 1'b0;
    #20;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", 32'(bus.in_ready), 32'd0);
    step();
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("dbz", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run_div("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
    run_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    run_div("msb_path", 32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0, 33);
    run_div("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    // Backpressure, then a request presented together with the response handshake.
    issue(32'd1000, 32'd10);
    wait_result("bp", 33);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_q", bus.quotient, 32'd100);
      check("bp_hold_r", bus.remainder, 32'd0);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
    check("b2b_idle_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_accepted", 32'(bus.in_ready), 32'd0);
    wait_result("b2b", 33);
    expect_result("b2b", 32'd4, 32'd1, 1'b0);
    drain("b2b");

    // Flush at count 16.
    issue(32'd1000, 32'd3);
    repeat (16) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) rose++;
      step();
    end
    check("flush_no_valid", 32'(rose), 32'd0);
    run_div("d40_6", 32'd40, 32'd6, 32'd6, 32'd4, 1'b0, 33);

    // Asynchronous reset while a result is pending.
    issue(32'd77, 32'd5);
    wait_result("rst_done", 33);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_q", bus.quotient, 32'd0);
    check("rst_done_r", bus.remainder, 32'd0);
    check("rst_done_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_done_rel_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset mid-RUN.
    issue(32'd100, 32'd7);
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 check("rst_run_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) rose++;
    end
    check("rst_run_no_valid", 32'(rose), 32'd0);
    check("rst_run_ready_after", 32'(bus.in_ready), 32'd1);

    // Random operands with stalls and occasional flush.
    for (int k = 0; k < 200; k++) begin
      int mode;
      mode = int'($urandom_range(0, 7));
      dvd  = $urandom;
      dvs  = $urandom;
      if (mode == 0) dvs = 32'd0;
      else if (mode == 1) dvs = 32'($urandom_range(1, 255));
      eq = (dvs == 0) ? 32'hFFFF_FFFF : dvd / dvs;
      er = (dvs == 0) ? dvd : dvd % dvs;
      issue(dvd, dvs);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 30)) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("rnd_flush_valid", 32'(bus.out_valid), 32'd0);
        check("rnd_flush_ready", 32'(bus.in_ready), 32'd1);
      end else begin
        wait_result("rnd", (dvs == 0) ? 1 : 33);
        repeat ($urandom_range(0, 3)) step();
        expect_result("rnd", eq, er, dvs == 0);
        drain("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
